// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control
// decoder) and the execute-unit FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the execute-stage ALU. The producer (decoder /
// register-read path) uses master, the ALU uses slave.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of a*b. One partial
// product per cycle, fixed WIDTH iterations, no early termination.
// done/product are combinational on the final iteration so the caller can
// register the finished product on the same edge as the last add.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             run;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
    assign done    = run && (count == LAST);
    assign product = acc_nxt;

    // Capture operands on start, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST) run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative MUL,
// with a one-entry registered output slot behind valid/ready handshakes.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    alu_state_e       state;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_res;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    // Slot may be refilled while it drains, so out_ready opens the input.
    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = (state == MUL);

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = (bus.alu_ctrl == ALU_MUL);

    // Single-cycle datapath; unknown codes produce 0.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            ALU_AND: alu_res = bus.op_a & bus.op_b;
            ALU_OR:  alu_res = bus.op_a | bus.op_b;
            ALU_ADD: alu_res = bus.op_a + bus.op_b;
            ALU_SUB: alu_res = bus.op_a - bus.op_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.op_a) < $signed(bus.op_b))};
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM and output slot: consume clears valid unless a new result loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (bus.out_ready) out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result_q    <= mul_prod;
                        zero_q      <= (mul_prod == '0);
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder, plus two operands, and returns a registered result and zero flag over valid/ready handshakes. Single-cycle operations (AND, OR, ADD, SUB, SLT) complete with one-cycle latency. MUL (low word) runs on an iterative shift-add datapath with fixed latency. The block sits between the ALU control decoder / register-read path and the writeback/branch-compare logic.

## Interface
- WIDTH, 32, operand and result width; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block accepts the operation this cycle.
- alu_ctrl  in  4  operation code, sampled on accept.
- op_a  in  WIDTH  first operand, sampled on accept.
- op_b  in  WIDTH  second operand, sampled on accept.
- out_valid  out  1  result and zero are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  WIDTH  operation result.
- zero  out  1  (result == 0); meaningful only while out_valid.
- busy  out  1  a MUL is in progress.

## Operation
- Codes: 4'b0000 AND; 4'b0001 OR; 4'b0010 ADD; 4'b0110 SUB; 4'b0111 SLT (signed; result is 1 or 0); 4'b1000 MUL (low WIDTH bits of a*b).
- Any other code: result = 0, zero = 1, single-cycle.
- ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- MUL low word is the same for signed and unsigned operands, so an unsigned shift-add is used.
- An accept is the condition in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- States:
  - IDLE: on accepting a single-cycle op, the result register loads the result, zero loads, and out_valid is set. State stays IDLE.
  - IDLE: on accepting MUL, multiplicand, multiplier and count = 0 are captured, accumulator is cleared, and the state moves to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Shift the multiplicand left and the multiplier right, and increment count. On the iteration with count == WIDTH-1, load result and zero, set out_valid, and return to IDLE.
- Output register: out_valid clears on out_ready when no new result loads in the same cycle. A simultaneous consume and load keeps out_valid = 1 with the new data.
- While out_valid && !out_ready, result and zero hold stable.
- A MUL never completes into an occupied slot. in_ready gating guarantees the slot is empty or draining at accept, and no second op is accepted during MUL.
- busy = (state == MUL).

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, zero 0, busy 0, state IDLE, count 0.
- Single-cycle ops: accepted at edge N, out_valid = 1 after edge N+1 (latency 1). Throughput is 1 op per cycle when out_ready is held high.
- MUL: accepted at edge N, out_valid = 1 after edge N+WIDTH. Latency is fixed and there is no early termination. in_ready = 0 for cycles N+1 through N+WIDTH.
- Reset asserted mid-MUL or mid-hold aborts immediately. All registers take their reset values and the pending result is discarded.
- Inputs are ignored whenever in_ready = 0.

## Structure
- Shared package `alu_pkg`: the 4-bit operation-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL) and the state enum. The ALU control decoder must use the same constants.
- One sub-module: `alu_mul_iter`.
  - Contains the shift-add datapath and the count.
  - Interface: start, a, b, done, product.
- The top level holds the single-cycle datapath, the FSM and the output register.

## Test plan
- ADD 5 + 7, out_ready = 1 → one cycle later: result 12, zero 0, out_valid pulse of 1 cycle.
- SUB 0x1234 − 0x1234 → result 0, zero 1. SUB 0 − 1 → result 0xFFFFFFFF.
- SLT 0xFFFFFFFF vs 1 → result 1. AND 0xF0F0 & 0x0FF0 → 0x00F0. OR → 0xFFF0.
- MUL 0xFFFFFFFF × 3 → result 0xFFFFFFFD exactly 32 cycles after accept. busy is high and in_ready is low throughout.
- Backpressure test:
  - Issue ADD 1 + 1 with out_ready = 0 for 5 cycles.
  - Required: result 2 held stable and in_ready = 0.
  - Then raise out_ready with a new ADD presented.
  - Required: new result appears next cycle with out_valid continuous.
- Reset at cycle 10 of a MUL → all outputs at reset values, no out_valid afterwards. The next ADD 2 + 2 returns 4 with latency 1.
